load_stall_ctrl: RTL and testbench

//  Responder to the hazard-detect unit's load-use stall request. Sequences a stall: freezes PC/IF-ID,

---
 rtl/load_stall_ctrl_pkg.sv | 17 +
 rtl/load_stall_ctrl_if.sv | 32 +++
 rtl/load_stall_ctrl_sat_counter.sv | 24 ++
 rtl/load_stall_ctrl.sv | 132 +++++++++++++
 tb/tb_load_stall_ctrl.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/load_stall_ctrl_pkg.sv
// Shared types and constants for the load-use stall controller.
// Holds the FSM state encoding, register-address width and the R0 tag.
package load_stall_ctrl_pkg;

    localparam int REG_AW     = 4;
    localparam int PERF_W_DEF = 16;

    localparam logic [REG_AW-1:0] R0 = {REG_AW{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_MEM = 2'd1,
        ST_WAIT_WB  = 2'd2,
        ST_RELEASE  = 2'd3
    } state_e;

endpackage

// File: rtl/load_stall_ctrl_if.sv
// Bundle between hazard unit / memory / writeback and the stall controller.
// The environment drives through master; the controller attaches as slave.
interface load_stall_ctrl_if
    import load_stall_ctrl_pkg::*;
#(
    parameter int PERF_W = PERF_W_DEF
);
    logic              hd_stall_req;
    logic              e_isLoad;
    logic [REG_AW-1:0] e_wreg;
    logic              mem_ready;
    logic              wb_wen;
    logic [REG_AW-1:0] wb_waddr;
    logic              flush;
    logic              write_done;
    logic              pc_en;
    logic              ifid_en;
    logic              idex_bubble;
    logic              stall_active;
    logic              timeout_err;
    logic [PERF_W-1:0] stall_cycles;

    modport master (
        output hd_stall_req, e_isLoad, e_wreg, mem_ready, wb_wen, wb_waddr, flush,
        input  write_done, pc_en, ifid_en, idex_bubble, stall_active, timeout_err, stall_cycles
    );

    modport slave (
        input  hd_stall_req, e_isLoad, e_wreg, mem_ready, wb_wen, wb_waddr, flush,
        output write_done, pc_en, ifid_en, idex_bubble, stall_active, timeout_err, stall_cycles
    );
endinterface

// File: rtl/load_stall_ctrl_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module load_stall_ctrl_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    output logic [W-1:0] count_o
);
    logic [W-1:0] count_q;

    // Count enabled cycles until the all-ones ceiling is reached.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= {W{1'b0}};
        end else if (en_i && (count_q != {W{1'b1}})) begin
            count_q <= count_q + {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_q <= count_q;
        end
    end

    assign count_o = count_q;
endmodule

// File: rtl/load_stall_ctrl.sv
// Load-use stall sequencer: freezes fetch, bubbles ID/EX and waits for the
// stalling load's writeback (by register tag) before releasing with write_done.
module load_stall_ctrl
    import load_stall_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 15,
    parameter int PERF_W  = PERF_W_DEF
) (
    input logic               clk,
    input logic               rst_n,
    load_stall_ctrl_if.slave  bus
);
    localparam int CNT_W = $clog2(TIMEOUT);

    state_e             state_q, state_d;
    logic [REG_AW-1:0]  tag_q, tag_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic               guard_q, guard_d;
    logic               timeout_err_q, timeout_err_d;
    logic               write_done_q, pc_en_q, ifid_en_q, idex_bubble_q, stall_active_q;
    logic               wb_hit_s, guard_blk_s, expired_s, accept_s, stalling_d_s;
    logic [PERF_W-1:0]  stall_cycles_s;

    assign wb_hit_s    = bus.wb_wen && (bus.wb_waddr == tag_q);
    // Guard only suppresses a request that still names the load just released.
    assign guard_blk_s = guard_q && bus.e_isLoad && (bus.e_wreg == tag_q);
    assign expired_s   = (wait_cnt_q == CNT_W'(TIMEOUT - 1));
    assign accept_s    = bus.hd_stall_req && bus.e_isLoad && (bus.e_wreg != R0) && !guard_blk_s;

    // Next-state logic; flush outranks completion, completion outranks timeout.
    always_comb begin
        state_d       = state_q;
        tag_d         = tag_q;
        wait_cnt_d    = wait_cnt_q;
        guard_d       = guard_q;
        timeout_err_d = timeout_err_q;
        if (bus.flush) begin
            state_d    = ST_IDLE;
            guard_d    = 1'b0;
            wait_cnt_d = {CNT_W{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    guard_d = guard_blk_s;
                    if (accept_s) begin
                        state_d    = ST_WAIT_MEM;
                        tag_d      = bus.e_wreg;
                        wait_cnt_d = {CNT_W{1'b0}};
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_WAIT_MEM: begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                    if (bus.mem_ready && wb_hit_s) begin
                        state_d = ST_RELEASE;
                    end else if (expired_s) begin
                        state_d       = ST_RELEASE;
                        timeout_err_d = 1'b1;
                    end else if (bus.mem_ready) begin
                        state_d = ST_WAIT_WB;
                    end else begin
                        state_d = ST_WAIT_MEM;
                    end
                end
                ST_WAIT_WB: begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                    if (wb_hit_s) begin
                        state_d = ST_RELEASE;
                    end else if (expired_s) begin
                        state_d       = ST_RELEASE;
                        timeout_err_d = 1'b1;
                    end else begin
                        state_d = ST_WAIT_WB;
                    end
                end
                ST_RELEASE: begin
                    state_d    = ST_IDLE;
                    guard_d    = 1'b1;
                    wait_cnt_d = {CNT_W{1'b0}};
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign stalling_d_s = (state_d == ST_WAIT_MEM) || (state_d == ST_WAIT_WB);

    // State, tracking registers and outputs registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            tag_q          <= R0;
            wait_cnt_q     <= {CNT_W{1'b0}};
            guard_q        <= 1'b0;
            timeout_err_q  <= 1'b0;
            write_done_q   <= 1'b0;
            pc_en_q        <= 1'b1;
            ifid_en_q      <= 1'b1;
            idex_bubble_q  <= 1'b0;
            stall_active_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            tag_q          <= tag_d;
            wait_cnt_q     <= wait_cnt_d;
            guard_q        <= guard_d;
            timeout_err_q  <= timeout_err_d;
            write_done_q   <= (state_d == ST_RELEASE);
            pc_en_q        <= !stalling_d_s;
            ifid_en_q      <= !stalling_d_s;
            idex_bubble_q  <= stalling_d_s;
            stall_active_q <= (state_d != ST_IDLE);
        end
    end

    load_stall_ctrl_sat_counter #(.W(PERF_W)) u_stall_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (!pc_en_q),
        .count_o (stall_cycles_s)
    );

    assign bus.write_done   = write_done_q;
    assign bus.pc_en        = pc_en_q;
    assign bus.ifid_en      = ifid_en_q;
    assign bus.idex_bubble  = idex_bubble_q;
    assign bus.stall_active = stall_active_q;
    assign bus.timeout_err  = timeout_err_q;
    assign bus.stall_cycles = stall_cycles_s;
endmodule

// File: tb/tb_load_stall_ctrl.sv
// Directed bench for load_stall_ctrl: vector table plus timeout, async reset
// and counter-saturation sequences. Counter narrowed to 5 bits to reach saturation.
module tb_load_stall_ctrl;
    localparam int PW = 5;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    load_stall_ctrl_if #(.PERF_W(PW)) bus ();

    load_stall_ctrl #(.TIMEOUT(15), .PERF_W(PW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       req;
        logic       isl;
        logic [3:0] wreg;
        logic       memr;
        logic       wen;
        logic [3:0] waddr;
        logic       fl;
        logic       wd;
        logic       pc;
        logic       act;
        int         sc;
    } vec_t;

    vec_t tbl [29];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input logic req, input logic isl, input logic [3:0] wreg,
                         input logic memr, input logic wen, input logic [3:0] waddr,
                         input logic fl);
        @(negedge clk);
        bus.hd_stall_req = req;
        bus.e_isLoad     = isl;
        bus.e_wreg       = wreg;
        bus.mem_ready    = memr;
        bus.wb_wen       = wen;
        bus.wb_waddr     = waddr;
        bus.flush        = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        apply(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic do_timeout(input logic [3:0] tag, input int sc_exp);
        apply(1'b1, 1'b1, tag, 1'b0, 1'b0, 4'd0, 1'b0);
        chk("to_accept_pc_en", int'(bus.pc_en), 0);
        for (int i = 1; i < 15; i++) begin
            idle();
            chk("to_wait_pc_en", int'(bus.pc_en), 0);
            chk("to_wait_write_done", int'(bus.write_done), 0);
        end
        idle();
        chk("to_release_write_done", int'(bus.write_done), 1);
        chk("to_release_pc_en", int'(bus.pc_en), 1);
        chk("to_release_timeout_err", int'(bus.timeout_err), 1);
        chk("to_release_stall_cycles", int'(bus.stall_cycles), sc_exp);
        idle();
        chk("to_after_write_done", int'(bus.write_done), 0);
        chk("to_sticky_timeout_err", int'(bus.timeout_err), 1);
        chk("to_after_active", int'(bus.stall_active), 0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        // req isl wreg memr wen waddr fl | wd pc act sc
        tbl[0]  = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 0};
        tbl[1]  = '{1'b1, 1'b1, 4'd3, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 0};
        tbl[2]  = '{1'b1, 1'b1, 4'd3, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1};
        tbl[3]  = '{1'b1, 1'b1, 4'd3, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2};
        tbl[4]  = '{1'b1, 1'b1, 4'd3, 1'b0, 1'b1, 4'd3, 1'b0, 1'b1, 1'b1, 1'b1, 3};
        tbl[5]  = '{1'b1, 1'b1, 4'd3, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3};
        tbl[6]  = '{1'b1, 1'b1, 4'd3, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3};
        tbl[7]  = '{1'b1, 1'b1, 4'd4, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3};
        tbl[8]  = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b1, 4};
        tbl[9]  = '{1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5};
        tbl[10] = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b1, 6};
        tbl[11] = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd4, 1'b0, 1'b1, 1'b1, 1'b1, 7};
        tbl[12] = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 7};
        tbl[13] = '{1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 7};
        tbl[14] = '{1'b1, 1'b1, 4'd2, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 7};
        tbl[15] = '{1'b1, 1'b1, 4'd2, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 7};
        tbl[16] = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8};
        tbl[17] = '{1'b1, 1'b0, 4'd6, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8};
        tbl[18] = '{1'b1, 1'b1, 4'd6, 1'b1, 1'b1, 4'd6, 1'b0, 1'b0, 1'b0, 1'b1, 8};
        tbl[19] = '{1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd6, 1'b0, 1'b1, 1'b1, 1'b1, 9};
        tbl[20] = '{1'b1, 1'b1, 4'd6, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 9};
        tbl[21] = '{1'b1, 1'b1, 4'd6, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 9};
        tbl[22] = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 9};
        tbl[23] = '{1'b1, 1'b1, 4'd6, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 9};
        tbl[24] = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 10};
        tbl[25] = '{1'b1, 1'b1, 4'd7, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 10};
        tbl[26] = '{1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 11};
        tbl[27] = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd7, 1'b1, 1'b0, 1'b1, 1'b0, 12};
        tbl[28] = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 12};

        rst_n            = 1'b0;
        bus.hd_stall_req = 1'b0;
        bus.e_isLoad     = 1'b0;
        bus.e_wreg       = 4'd0;
        bus.mem_ready    = 1'b0;
        bus.wb_wen       = 4'd0 != 4'd0;
        bus.wb_waddr     = 4'd0;
        bus.flush        = 1'b0;
        #12;
        chk("rst_write_done", int'(bus.write_done), 0);
        chk("rst_pc_en", int'(bus.pc_en), 1);
        chk("rst_ifid_en", int'(bus.ifid_en), 1);
        chk("rst_idex_bubble", int'(bus.idex_bubble), 0);
        chk("rst_stall_active", int'(bus.stall_active), 0);
        chk("rst_timeout_err", int'(bus.timeout_err), 0);
        chk("rst_stall_cycles", int'(bus.stall_cycles), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 29; i++) begin
            apply(tbl[i].req, tbl[i].isl, tbl[i].wreg, tbl[i].memr,
                  tbl[i].wen, tbl[i].waddr, tbl[i].fl);
            chk($sformatf("v%0d_write_done", i), int'(bus.write_done), int'(tbl[i].wd));
            chk($sformatf("v%0d_pc_en", i), int'(bus.pc_en), int'(tbl[i].pc));
            chk($sformatf("v%0d_ifid_en", i), int'(bus.ifid_en), int'(tbl[i].pc));
            chk($sformatf("v%0d_idex_bubble", i), int'(bus.idex_bubble),
                (tbl[i].act && !tbl[i].pc) ? 1 : 0);
            chk($sformatf("v%0d_stall_active", i), int'(bus.stall_active), int'(tbl[i].act));
            chk($sformatf("v%0d_timeout_err", i), int'(bus.timeout_err), 0);
            chk($sformatf("v%0d_stall_cycles", i), int'(bus.stall_cycles), tbl[i].sc);
        end

        // Memory never answers: forced release after 15 stalled cycles.
        do_timeout(4'd1, 27);

        // Asynchronous reset in the middle of a stall.
        apply(1'b1, 1'b1, 4'd3, 1'b0, 1'b0, 4'd0, 1'b0);
        chk("mid_pc_en", int'(bus.pc_en), 0);
        @(negedge clk);
        bus.hd_stall_req = 1'b0;
        bus.e_isLoad     = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_pc_en", int'(bus.pc_en), 1);
        chk("async_rst_idex_bubble", int'(bus.idex_bubble), 0);
        chk("async_rst_stall_active", int'(bus.stall_active), 0);
        chk("async_rst_timeout_err", int'(bus.timeout_err), 0);
        chk("async_rst_stall_cycles", int'(bus.stall_cycles), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Three forced releases push the 5-bit counter past its ceiling.
        do_timeout(4'd1, 15);
        do_timeout(4'd2, 30);
        do_timeout(4'd3, 31);
        idle();
        chk("sat_hold_stall_cycles", int'(bus.stall_cycles), 31);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
